// File: rtl/mem_pkg.sv
// Shared encodings for the data memory slice: access sizes, controller
// states and byte-lane geometry.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bus between the MEM stage and the data memory.
// master: issues requests and consumes responses; slave: the memory.
interface data_memory_sized_if;

  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        rsp_valid;
  logic [31:0] read_data;
  logic        rsp_err;
  logic        init_done;

  modport master (
    output req_valid, mem_read, mem_write, mem_size, mem_unsigned,
           address, write_data,
    input  req_ready, rsp_valid, read_data, rsp_err, init_done
  );

  modport slave (
    input  req_valid, mem_read, mem_write, mem_size, mem_unsigned,
           address, write_data,
    output req_ready, rsp_valid, read_data, rsp_err, init_done
  );

endinterface

// File: rtl/mem_load_align.sv
// Load alignment: moves the addressed byte/half of a word to bit 0 and
// sign- or zero-extends it.
// Ports: word (raw RAM word), lane (address[1:0]), size (access size),
//        is_unsigned (1 = zero-extend), load_data_c (extended result).
module mem_load_align
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  size_e             size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] load_data_c
);

  logic [WORD_W-1:0] shifted_c;

  assign shifted_c = word >> {lane, 3'b000};

  // Extend the selected field; word loads pass through (lane is 0 when legal).
  always_comb begin
    load_data_c = '0;
    unique case (size)
      SIZE_BYTE: load_data_c = is_unsigned ? {24'd0, shifted_c[7:0]}
                                           : {{24{shifted_c[7]}}, shifted_c[7:0]};
      SIZE_HALF: load_data_c = is_unsigned ? {16'd0, shifted_c[15:0]}
                                           : {{16{shifted_c[15]}}, shifted_c[15:0]};
      SIZE_WORD: load_data_c = shifted_c;
      default:   load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Data memory for the MEM stage: word RAM with byte/half/word access,
// registered one-cycle responses, error reporting, and a post-reset
// zero-fill sequence that clears one word per cycle.
// Ports: clk, reset (async active-low), bus (slave side of
//        data_memory_sized_if: request, response, req_ready, init_done).
module data_memory_sized
  import mem_pkg::*;
#(
  parameter int unsigned RAM_SIZE_BIT   = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_sized_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << RAM_SIZE_BIT;
  localparam logic [RAM_SIZE_BIT-1:0] LAST_IDX = '1;
  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  logic [WORD_W-1:0] mem [DEPTH];

  state_e                  state_q, state_d;
  logic [RAM_SIZE_BIT-1:0] clr_cnt_q, clr_cnt_d;
  logic                    clr_we_c;
  logic                    accept_c;

  size_e                   size_c;
  logic [1:0]              lane_c;
  logic [RAM_SIZE_BIT-1:0] idx_c;
  logic                    oor_c;
  logic                    err_c;
  logic                    store_we_c;
  logic [LANES-1:0]        lane_mask_c;
  logic [WORD_W-1:0]       wdata_rep_c;
  logic [WORD_W-1:0]       rd_word_c;
  logic [WORD_W-1:0]       load_data_c;

  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [WORD_W-1:0]       read_data_q;
  logic                    init_done_q;

  assign size_c = size_e'(bus.mem_size);
  assign lane_c = bus.address[1:0];
  assign idx_c  = bus.address[RAM_SIZE_BIT+1:2];
  assign oor_c  = (bus.address >> (RAM_SIZE_BIT + 2)) != 32'd0;

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: sweep every word once, then accept requests.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_c  = 1'b0;
    accept_c  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we_c  = 1'b1;
        clr_cnt_d = clr_cnt_q + RAM_SIZE_BIT'(1);
        if (clr_cnt_q == LAST_IDX) state_d = READY;
      end
      READY: accept_c = bus.req_valid;
      default: state_d = RESET_STATE;
    endcase
  end

  // Illegal request detection.
  always_comb begin
    err_c = (bus.mem_read == bus.mem_write) || oor_c;
    unique case (size_c)
      SIZE_HALF: if (lane_c[0])      err_c = 1'b1;
      SIZE_WORD: if (lane_c != 2'b0) err_c = 1'b1;
      SIZE_RSVD: err_c = 1'b1;
      default:   ;
    endcase
  end

  // Store lane enables and right-aligned data replicated across lanes.
  always_comb begin
    lane_mask_c = '0;
    wdata_rep_c = '0;
    unique case (size_c)
      SIZE_BYTE: begin
        lane_mask_c = 4'b0001 << lane_c;
        wdata_rep_c = {4{bus.write_data[7:0]}};
      end
      SIZE_HALF: begin
        lane_mask_c = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{bus.write_data[15:0]}};
      end
      SIZE_WORD: begin
        lane_mask_c = 4'b1111;
        wdata_rep_c = bus.write_data;
      end
      default: ;
    endcase
  end

  assign store_we_c = accept_c && bus.mem_write && !err_c;

  // RAM array: no reset; cleared by the sweep instead.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_cnt_q] <= '0;
    end else if (store_we_c) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (lane_mask_c[b]) mem[idx_c][b*8 +: 8] <= wdata_rep_c[b*8 +: 8];
      end
    end
  end

  assign rd_word_c = mem[idx_c];

  mem_load_align u_load_align (
    .word        (rd_word_c),
    .lane        (lane_c),
    .size        (size_c),
    .is_unsigned (bus.mem_unsigned),
    .load_data_c (load_data_c)
  );

  // Response registers; read_data holds on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      read_data_q <= '0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      rsp_valid_q <= accept_c;
      init_done_q <= (state_d == READY);
      if (accept_c) begin
        rsp_err_q   <= err_c;
        read_data_q <= (err_c || !bus.mem_read) ? '0 : load_data_c;
      end
    end
  end

  assign bus.req_ready = (state_q == READY);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.read_data = read_data_q;
  assign bus.init_done = init_done_q;

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Next-generation data memory for the pipeline CPU MEM stage.
- Word-organised RAM with byte, half-word and word access, sign/zero-extended loads, and byte-lane stores.
- Registered read with a one-cycle response, plus alignment and range error reporting.
- After reset, a sequential clear FSM zeroes the RAM one word per cycle. This replaces a bulk reset of the whole array.

Parameters:
- RAM_SIZE_BIT, default 8: log2 of depth in 32-bit words (256 words = 1 KiB).
- CLEAR_ON_RESET, default 1: 1 = run the zero-fill FSM after reset; 0 = skip straight to READY (contents undefined).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present this cycle
- req_ready  out  1  block accepts requests (high only in READY)
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- mem_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- address  in  32  byte address
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response valid, exactly one cycle after an accepted request
- read_data  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  accepted request was illegal (no side effect)
- init_done  out  1  clear sequence complete

Behaviour:
- Reset (reset = 0, async):
  - state = CLEAR if CLEAR_ON_RESET, else READY.
  - Clear counter = 0.
  - rsp_valid = 0, rsp_err = 0, read_data = 0.
  - init_done = 0 (= 1 if CLEAR_ON_RESET = 0); req_ready follows state.
  - RAM contents are not reset asynchronously.
- CLEAR state:
  - Each cycle writes 0 to word[counter], then counter += 1.
  - When counter = 2^RAM_SIZE_BIT - 1 is written, go to READY; init_done = 1 from the next cycle.
  - Duration is exactly 2^RAM_SIZE_BIT cycles.
  - req_ready = 0. Requests are ignored; no response is generated.
- READY state:
  - A request is accepted when req_valid & req_ready.
  - The response appears on the next cycle: rsp_valid = 1 for one cycle, with read_data and rsp_err registered.
  - One request per cycle, fully pipelined, no back-pressure.
- Word index = address[RAM_SIZE_BIT+1:2]. Byte lane = address[1:0].
- Error conditions. Any of these sets rsp_err = 1, suppresses the write, and forces read_data = 0:
  - mem_read & mem_write both high
  - neither mem_read nor mem_write high
  - mem_size = 11
  - half access with address[0] = 1
  - word access with address[1:0] != 0
  - address[31:RAM_SIZE_BIT+2] != 0 (out of range)
- Store:
  - Byte lanes enabled per size/offset: byte = 1 lane; half = lanes {1:0} or {3:2}; word = all lanes.
  - Data is replicated into the selected lane(s); other lanes are unchanged.
  - The write commits at the accepting edge.
- Load:
  - The word is read at the accepting edge.
  - The selected byte/half is shifted to bit 0, then sign- or zero-extended per mem_unsigned.
  - mem_unsigned is ignored for word loads.
- Store followed by a load to the same word on the next cycle returns the new data; no forwarding is needed because the write commits first.
- A load and a store never coincide in one request, so there is no same-cycle read/write hazard.
- reset asserted mid-CLEAR or mid-response: immediate return to reset values; CLEAR restarts from word 0.
- Idle cycles (no accept) give rsp_valid = 0. read_data holds its last value; consumers must qualify with rsp_valid.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE / SIZE_HALF / SIZE_WORD
  - state encoding CLEAR / READY
  - byte-lane mask width constant 4
- One natural sub-module, mem_load_align: combinational lane select plus sign/zero extension. It is reusable by a future I/O bus.
- Lane mask generation and the clear FSM stay in the top level.

Test Plan:
- Reset then idle, RAM_SIZE_BIT = 4:
  - init_done rises after exactly 16 cycles.
  - req_ready = 0 throughout CLEAR.
  - A word load of address 0x3C then returns 0x00000000.
- Word store of 0x80FF7F01 to 0x10, then byte loads:
  - 0x10 signed → 0x00000001
  - 0x11 signed → 0x0000007F
  - 0x12 signed → 0xFFFFFFFF
  - 0x13 unsigned → 0x00000080
- Half store of 0xBEEF to 0x22 over existing 0x11223344:
  - Word load of 0x20 → 0xBEEF3344.
  - Signed half load of 0x22 → 0xFFFFBEEF.
- Back-to-back pipelining: store 0xDEADBEEF to 0x04 in cycle N, word load of 0x04 in cycle N+1.
  - rsp_valid high in N+1 and N+2.
  - N+2 read_data = 0xDEADBEEF.
- Error cases:
  - Word store to 0x06 → rsp_err = 1, word 1 unchanged.
  - Half load at 0x01 → rsp_err = 1, read_data = 0.
  - Load at 0x00000400 (RAM_SIZE_BIT = 8) → rsp_err = 1.
  - mem_read & mem_write both high → rsp_err = 1, no write.
- reset pulsed low during CLEAR at counter 7:
  - rsp_valid = 0 and init_done = 0 immediately.
  - Clear restarts; init_done rises 2^RAM_SIZE_BIT cycles after reset release.
